// File: rtl/rng_share_ctrl_if.sv
// Draw request/grant bus between the shared RNG controller and its requesters.
interface rng_share_ctrl_if #(
  parameter int unsigned BITL = 16,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [BITL-1:0] rnd_data;

  modport master (output req, input gnt, input rnd_valid, input rnd_data);
  modport slave  (input req, output gnt, output rnd_valid, output rnd_data);
endinterface

// File: rtl/rng_share_ctrl.sv
// Seeds, warms up and round-robin shares one LFSR among NREQ requesters.
// Optional draw counter output enabled by RNG_SHARE_CTRL_DRAW_CNT_EN.
module rng_share_ctrl #(
  parameter int unsigned     BITL         = 16,
  parameter int unsigned     NREQ         = 4,
  parameter int unsigned     WARMUP       = 8,
  parameter logic [BITL-1:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BITL-1:0]   seed_in,
  input  logic              reseed,
  rng_share_ctrl_if.slave   bus,
  output logic              busy,
  output logic              rng_reset,
  output logic [BITL-1:0]   rng_seed,
`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
  input  logic [BITL-1:0]   rng_data,
  output logic [31:0]       draw_cnt
`else
  input  logic [BITL-1:0]   rng_data
`endif
);

  localparam int unsigned     LW        = $clog2(NREQ);
  localparam int unsigned     WW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0]   WLAST     = (WARMUP > 1) ? WW'(WARMUP - 1) : '0;
  localparam logic [LW-1:0]   LAST_INIT = LW'(NREQ - 1);

  typedef enum logic [1:0] {SEED, WARM, RUN} state_e;

  state_e          state_q, state_d;
  logic [BITL-1:0] seed_q, seed_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [LW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rnd_valid_q, rnd_valid_d;
  logic [BITL-1:0] rnd_data_q, rnd_data_d;

  logic            hit;
  logic [LW-1:0]   pick;
  logic [LW-1:0]   arb_idx;
  logic            draw_fire;

  // Rotating priority: the requester after the last winner is checked first.
  always_comb begin
    hit     = 1'b0;
    pick    = '0;
    arb_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arb_idx = LW'((32'(last_q) + k) % NREQ);
      if (!hit && bus.req[arb_idx]) begin
        hit  = 1'b1;
        pick = arb_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    wcnt_d      = wcnt_q;
    last_d      = last_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data_q;
    draw_fire   = 1'b0;
    if (reseed) begin
      seed_d  = seed_in;
      state_d = SEED;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        SEED: begin
          wcnt_d  = '0;
          state_d = (WARMUP == 0) ? RUN : WARM;
        end
        WARM: begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WLAST) state_d = RUN;
        end
        RUN: begin
          if (hit) begin
            gnt_d       = NREQ'(1) << pick;
            rnd_valid_d = 1'b1;
            rnd_data_d  = rng_data;
            last_d      = pick;
            draw_fire   = 1'b1;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      seed_q      <= SEED_DEFAULT;
      wcnt_q      <= '0;
      last_q      <= LAST_INIT;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      wcnt_q      <= wcnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  // Generator reset is combinational so it tracks controller reset immediately.
  assign rng_reset     = reset | (state_q == SEED);
  assign rng_seed      = seed_q;
  assign busy          = (state_q != RUN);
  assign bus.gnt       = gnt_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.rnd_data  = rnd_data_q;

`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reseed)         cnt_d = '0;
    else if (draw_fire) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign draw_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed, table-driven bench for rng_share_ctrl with a behavioural LFSR generator.
module tb_rng_share_ctrl;
  localparam int unsigned BITL = 16;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // DUT A: default warm-up
  logic            a_reset, a_reseed, a_busy, a_rng_reset;
  logic [BITL-1:0] a_seed_in, a_rng_seed, a_rng_data;
  rng_share_ctrl_if #(.BITL(BITL), .NREQ(NREQ)) a_if ();

  // DUT B: no warm-up
  logic            b_reset, b_reseed, b_busy, b_rng_reset;
  logic [BITL-1:0] b_seed_in, b_rng_seed, b_rng_data;
  rng_share_ctrl_if #(.BITL(BITL), .NREQ(NREQ)) b_if ();

`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
  logic [31:0] a_draw_cnt, b_draw_cnt;
`endif

  rng_share_ctrl #(.BITL(BITL), .NREQ(NREQ), .WARMUP(8), .SEED_DEFAULT(16'hACE1)) dut_a (
    .clk(clk), .reset(a_reset), .seed_in(a_seed_in), .reseed(a_reseed), .bus(a_if),
    .busy(a_busy), .rng_reset(a_rng_reset), .rng_seed(a_rng_seed),
`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
    .rng_data(a_rng_data), .draw_cnt(a_draw_cnt)
`else
    .rng_data(a_rng_data)
`endif
  );

  rng_share_ctrl #(.BITL(BITL), .NREQ(NREQ), .WARMUP(0), .SEED_DEFAULT(16'hACE1)) dut_b (
    .clk(clk), .reset(b_reset), .seed_in(b_seed_in), .reseed(b_reseed), .bus(b_if),
    .busy(b_busy), .rng_reset(b_rng_reset), .rng_seed(b_rng_seed),
`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
    .rng_data(b_rng_data), .draw_cnt(b_draw_cnt)
`else
    .rng_data(b_rng_data)
`endif
  );

  // Galois LFSR x^16+x^14+x^13+x^11+1 with zero escape
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h0) return 16'h0001;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] lfsr_n(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = lfsr_adv(r);
    return r;
  endfunction

  always @(posedge clk) a_rng_data <= a_rng_reset ? a_rng_seed : lfsr_adv(a_rng_data);
  always @(posedge clk) b_rng_data <= b_rng_reset ? b_rng_seed : lfsr_adv(b_rng_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // step < 0 means rnd_data must still be 0; otherwise rnd_data = ACE1 advanced step times
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic       busy;
    int         step;
  } vec_t;

  vec_t tbl[19];

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      a_if.req = tbl[i].req;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(a_if.gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(a_if.rnd_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_busy", i), 32'(a_busy), 32'(tbl[i].busy));
      if (tbl[i].step < 0)
        chk($sformatf("tbl%0d_data0", i), 32'(a_if.rnd_data), 32'h0);
      else
        chk($sformatf("tbl%0d_data", i), 32'(a_if.rnd_data), 32'(lfsr_n(16'hACE1, tbl[i].step)));
    end
  endtask

  logic [15:0] cap[32];
  logic [15:0] run1[32], run2[32], run3[32];

  task automatic capture(input logic [15:0] seed);
    int  waited;
    a_if.req  = 4'b0001;
    a_seed_in = seed;
    a_reseed  = 1'b1;
    @(posedge clk); #1;
    a_reseed = 1'b0;
    waited = 0;
    while (a_if.rnd_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk($sformatf("capture_%h_started", seed), 32'(a_if.rnd_valid), 32'h1);
    for (int i = 0; i < 32; i++) begin
      cap[i] = a_if.rnd_data;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int diff;
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 4'b0000, 1'b0, 1'b1, -1};
    tbl[8]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, -1};
    tbl[9]  = '{4'b1111, 4'b0001, 1'b1, 1'b0, 8};
    tbl[10] = '{4'b1111, 4'b0010, 1'b1, 1'b0, 9};
    tbl[11] = '{4'b1111, 4'b0100, 1'b1, 1'b0, 10};
    tbl[12] = '{4'b1111, 4'b1000, 1'b1, 1'b0, 11};
    tbl[13] = '{4'b1111, 4'b0001, 1'b1, 1'b0, 12};
    tbl[14] = '{4'b0101, 4'b0100, 1'b1, 1'b0, 13};
    tbl[15] = '{4'b0101, 4'b0001, 1'b1, 1'b0, 14};
    tbl[16] = '{4'b0101, 4'b0100, 1'b1, 1'b0, 15};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 15};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 15};

    a_reset = 1'b1; a_reseed = 1'b0; a_seed_in = '0; a_if.req = 4'b1111;
    b_reset = 1'b1; b_reseed = 1'b0; b_seed_in = '0; b_if.req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(a_if.gnt), 32'h0);
    chk("rst_valid", 32'(a_if.rnd_valid), 32'h0);
    chk("rst_data", 32'(a_if.rnd_data), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h1);
    chk("rst_rng_reset", 32'(a_rng_reset), 32'h1);
    chk("rst_rng_seed", 32'(a_rng_seed), 32'hACE1);

    a_reset = 1'b0;
    run_table(0, 18);

    // Reseed mid-RUN; last winner was requester 2
    a_if.req = 4'b1111; a_seed_in = 16'h1234; a_reseed = 1'b1;
    @(posedge clk); #1;
    a_reseed = 1'b0;
    chk("reseed_gnt", 32'(a_if.gnt), 32'h0);
    chk("reseed_valid", 32'(a_if.rnd_valid), 32'h0);
    chk("reseed_rng_reset", 32'(a_rng_reset), 32'h1);
    chk("reseed_rng_seed", 32'(a_rng_seed), 32'h1234);
    chk("reseed_busy", 32'(a_busy), 32'h1);
    @(posedge clk); #1;
    chk("reseed_rng_reset_drop", 32'(a_rng_reset), 32'h0);
    chk("reseed_gnt_seed", 32'(a_if.gnt), 32'h0);
    for (int k = 2; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("reseed_warm%0d_gnt", k), 32'(a_if.gnt), 32'h0);
    end
    @(posedge clk); #1;
    chk("resume0_gnt", 32'(a_if.gnt), 32'b1000);
    chk("resume0_data", 32'(a_if.rnd_data), 32'(lfsr_n(16'h1234, 8)));
    @(posedge clk); #1;
    chk("resume1_gnt", 32'(a_if.gnt), 32'b0001);
    chk("resume1_data", 32'(a_if.rnd_data), 32'(lfsr_n(16'h1234, 9)));
    @(posedge clk); #1;
    chk("resume2_gnt", 32'(a_if.gnt), 32'b0010);
    chk("resume2_data", 32'(a_if.rnd_data), 32'(lfsr_n(16'h1234, 10)));

    // Determinism across reseeds
    capture(16'h1234); run1 = cap;
    capture(16'h1234); run2 = cap;
    capture(16'h4321); run3 = cap;
    diff = 0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("det_model%0d", i), 32'(run1[i]), 32'(lfsr_n(16'h1234, 8 + i)));
      chk($sformatf("det_repeat%0d", i), 32'(run2[i]), 32'(run1[i]));
      if (run3[i] != run1[i]) diff++;
    end
    chk("seed4321_first", 32'(run3[0]), 32'(lfsr_n(16'h4321, 8)));
    chk("seed4321_differs", 32'(diff != 0), 32'h1);

    // Reset for 3 cycles mid-RUN
    a_if.req = 4'b1111;
    a_reset  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst%0d_gnt", k), 32'(a_if.gnt), 32'h0);
      chk($sformatf("midrst%0d_data", k), 32'(a_if.rnd_data), 32'h0);
      chk($sformatf("midrst%0d_rng_reset", k), 32'(a_rng_reset), 32'h1);
      chk($sformatf("midrst%0d_rng_seed", k), 32'(a_rng_seed), 32'hACE1);
    end
    a_reset = 1'b0;
    run_table(0, 13);

    // WARMUP=0 instance
    b_if.req = 4'b1111;
    b_reset  = 1'b0;
    @(posedge clk); #1;
    chk("w0_e1_gnt", 32'(b_if.gnt), 32'h0);
    chk("w0_e1_busy", 32'(b_busy), 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w0_g%0d_gnt", k), 32'(b_if.gnt), 32'(4'b0001 << (k % 4)));
      chk($sformatf("w0_g%0d_data", k), 32'(b_if.rnd_data), 32'(lfsr_n(16'hACE1, k)));
    end
    b_if.req = 4'b0000;
    @(posedge clk); #1;
    chk("w0_idle_valid", 32'(b_if.rnd_valid), 32'h0);
    chk("w0_idle_data_held", 32'(b_if.rnd_data), 32'(lfsr_n(16'hACE1, 4)));
`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
    chk("draw_cnt_5", b_draw_cnt, 32'd5);
`endif
    b_seed_in = 16'h0; b_reseed = 1'b1;
    @(posedge clk); #1;
    b_reseed = 1'b0;
    chk("w0_zero_seed", 32'(b_rng_seed), 32'h0);
`ifdef RNG_SHARE_CTRL_DRAW_CNT_EN
    chk("draw_cnt_clr", b_draw_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
